ctrl_sequencer: RTL and testbench

Parametrised successor to the Gumnut multi-cycle control FSM. Sequences fetch/decode/execute/mem/write-back/interrupt with a full interrupt-enable flag, a real standby state and a bus-ack timeout. It drives Wishbone-style cyc/stb/we for the instruction, data and port buses. It sits between the IR (op_i/func_i) and datapath/bus masters.

---
 rtl/ctrl_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control FSM for a Gumnut-style core.
// The FSM walks fetch / decode / execute / mem / write-back, with a separate
// interrupt-entry state and a standby state. It issues Wishbone-style requests
// on the instruction, data and port buses, and it aborts to interrupt entry
// when a bus ack does not arrive within ACK_TIMEOUT cycles.
//
// Optional build macro CTRL_SEQ_PERF_EN adds two ports: instret_o, which
// counts retired instructions, and stall_o, which counts bus stall cycles.
//
// Bus handshake: cyc/stb rise when the FSM enters a requesting state and stay
// high until the matching ack is sampled high on a rising edge. That edge
// completes the transfer and moves the FSM on. Acks on a bus that is not
// currently requested are ignored.
module ctrl_sequencer #(
    parameter int OP_W        = 7,
    parameter int FUNC_W      = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   op_i,
    input  logic [FUNC_W-1:0] func_i,
    input  logic              int_req_i,
    input  logic              inst_ack_i,
    input  logic              data_ack_i,
    input  logic              port_ack_i,
    output logic              inst_cyc_o,
    output logic              inst_stb_o,
    output logic              data_cyc_o,
    output logic              data_stb_o,
    output logic              data_we_o,
    output logic              port_cyc_o,
    output logic              port_stb_o,
    output logic              port_we_o,
    output logic              reg_wr_o,
    output logic              int_o,
    output logic              ie_o,
    output logic              bus_err_o,
`ifdef CTRL_SEQ_PERF_EN
    output logic [31:0]       instret_o,
    output logic [31:0]       stall_o,
`endif
    output logic [2:0]        state_o
);

    // Timeout counter width. It needs at least one bit even when the timeout
    // is disabled.
    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);
    localparam bit TO_EN = (ACK_TIMEOUT != 0);

    // Opcode classes. Every even opcode that matches none of these is an
    // ALU-immediate instruction. Every odd opcode is illegal.
    localparam logic [OP_W-1:0] OP_SHIFT  = OP_W'(7'b0000110);
    localparam logic [OP_W-1:0] OP_MEM    = OP_W'(7'b0000010);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b0111110);
    localparam logic [OP_W-1:0] OP_JUMP   = OP_W'(7'b0011110);
    localparam logic [OP_W-1:0] OP_MISC   = OP_W'(7'b1111110);
    localparam logic [OP_W-1:0] OP_ALUREG = OP_W'(7'b0001110);

    // Sub-function codes for the mem and misc classes.
    localparam logic [FUNC_W-1:0] F_LDM  = FUNC_W'(3'd0);
    localparam logic [FUNC_W-1:0] F_STM  = FUNC_W'(3'd1);
    localparam logic [FUNC_W-1:0] F_INP  = FUNC_W'(3'd2);
    localparam logic [FUNC_W-1:0] F_OUT  = FUNC_W'(3'd3);
    localparam logic [FUNC_W-1:0] F_RETI = FUNC_W'(3'd0);
    localparam logic [FUNC_W-1:0] F_ENAI = FUNC_W'(3'd2);
    localparam logic [FUNC_W-1:0] F_DISI = FUNC_W'(3'd3);
    localparam logic [FUNC_W-1:0] F_WAIT = FUNC_W'(3'd4);
    localparam logic [FUNC_W-1:0] F_STBY = FUNC_W'(3'd5);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_INT     = 3'd5,
        S_STBY    = 3'd6
    } state_t;

    state_t           state;
    state_t           state_next;
    state_t           end_state;
    state_t           mem_done_state;
    logic             ie_flag;
    logic             ie_next;
    logic [CNT_W-1:0] to_cnt;

    logic is_illegal;
    logic is_ctl_end;
    logic is_reti;
    logic is_enai;
    logic is_disi;
    logic is_sleep;
    logic use_data;
    logic use_port;
    logic bus_op;
    logic bus_read;
    logic bus_write;
    logic bus_ack;
    logic inter;
    logic counting;
    logic timeout;

    // Instruction decode. The opcode is held stable from DECODE until the
    // instruction ends, so these signals stay valid through EXECUTE/MEM/WB.
    // A mem-class opcode with an undefined sub-function (100..111) drives no
    // bus. It goes through EXECUTE and WB like an ALU operation.
    always_comb begin
        is_illegal = op_i[0];
        is_reti    = (op_i == OP_MISC) && (func_i == F_RETI);
        is_enai    = (op_i == OP_MISC) && (func_i == F_ENAI);
        is_disi    = (op_i == OP_MISC) && (func_i == F_DISI);
        is_sleep   = (op_i == OP_MISC) && ((func_i == F_WAIT) || (func_i == F_STBY));
        is_ctl_end = (op_i == OP_BRANCH) || (op_i == OP_JUMP) ||
                     ((op_i == OP_MISC) && !is_sleep);
        use_data   = (op_i == OP_MEM) && ((func_i == F_LDM) || (func_i == F_STM));
        use_port   = (op_i == OP_MEM) && ((func_i == F_INP) || (func_i == F_OUT));
        bus_op     = use_data || use_port;
        bus_read   = (op_i == OP_MEM) && ((func_i == F_LDM) || (func_i == F_INP));
        bus_write  = (op_i == OP_MEM) && ((func_i == F_STM) || (func_i == F_OUT));
        bus_ack    = (use_data && data_ack_i) || (use_port && port_ack_i);
    end

    // Instruction-end destination, plus the ack-wait detection that drives
    // the timeout. When an ack arrives in the same cycle the count reaches
    // the limit, the ack wins.
    always_comb begin
        inter          = int_req_i && ie_flag;
        end_state      = inter ? S_INT : S_FETCH;
        mem_done_state = bus_read ? S_WB : end_state;
        counting       = ((state == S_FETCH) && !inst_ack_i) ||
                         (((state == S_EXECUTE) || (state == S_MEM)) && bus_op && !bus_ack);
        timeout        = TO_EN && counting && (to_cnt == CNT_LIMIT);
    end

    // Next-state logic and next value of the interrupt-enable flag.
    // reti/enai/disi change ie. Their own end decision uses the old value.
    always_comb begin
        state_next = state;
        ie_next    = ie_flag;
        case (state)
            S_FETCH: begin
                if (inst_ack_i) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_INT;
                end
            end
            S_DECODE: begin
                if (is_illegal) begin
                    state_next = S_INT;
                end else if (is_ctl_end) begin
                    state_next = end_state;
                    if (is_reti || is_enai) begin
                        ie_next = 1'b1;
                    end else if (is_disi) begin
                        ie_next = 1'b0;
                    end
                end else if (is_sleep) begin
                    state_next = S_STBY;
                end else begin
                    state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (!bus_op) begin
                    state_next = S_WB;
                end else if (bus_ack) begin
                    state_next = mem_done_state;
                end else if (timeout) begin
                    state_next = S_INT;
                end else begin
                    state_next = S_MEM;
                end
            end
            S_MEM: begin
                if (bus_ack) begin
                    state_next = mem_done_state;
                end else if (timeout) begin
                    state_next = S_INT;
                end
            end
            S_WB: begin
                state_next = end_state;
            end
            S_INT: begin
                state_next = S_FETCH;
                ie_next    = 1'b0;
            end
            S_STBY: begin
                // With ie clear there is no way out except reset.
                if (inter) begin
                    state_next = S_INT;
                end
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State register and interrupt-enable flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ie_flag <= 1'b0;
        end else begin
            state   <= state_next;
            ie_flag <= ie_next;
        end
    end

    // Ack-wait counter. It restarts on every state change, so FETCH, EXECUTE
    // and MEM each get a full timeout window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state_next != state) begin
            to_cnt <= '0;
        end else if (TO_EN && counting) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // Outputs decoded from the current state. bus_err_o is the only output
    // that depends on this cycle's ack.
    always_comb begin
        inst_cyc_o = (state == S_FETCH);
        inst_stb_o = (state == S_FETCH);
        data_cyc_o = ((state == S_EXECUTE) || (state == S_MEM)) && use_data;
        data_stb_o = ((state == S_EXECUTE) || (state == S_MEM)) && use_data;
        data_we_o  = ((state == S_EXECUTE) || (state == S_MEM)) && use_data && bus_write;
        port_cyc_o = ((state == S_EXECUTE) || (state == S_MEM)) && use_port;
        port_stb_o = ((state == S_EXECUTE) || (state == S_MEM)) && use_port;
        port_we_o  = ((state == S_EXECUTE) || (state == S_MEM)) && use_port && bus_write;
        reg_wr_o   = (state == S_WB);
        int_o      = (state == S_INT);
        ie_o       = ie_flag;
        bus_err_o  = timeout;
        state_o    = state;
    end

`ifdef CTRL_SEQ_PERF_EN
    logic        retire;
    logic        stall;
    logic [31:0] instret_cnt;
    logic [31:0] stall_cnt;

    // Retire is any exit to FETCH/INT from an instruction-carrying state.
    // Stall is a FETCH or MEM cycle spent without the matching ack.
    always_comb begin
        retire = ((state == S_DECODE) || (state == S_EXECUTE) ||
                  (state == S_MEM) || (state == S_WB)) &&
                 ((state_next == S_FETCH) || (state_next == S_INT));
        stall  = ((state == S_FETCH) && !inst_ack_i) ||
                 ((state == S_MEM) && !bus_ack);
    end

    // Free-running performance counters. Both wrap at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (retire) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign instret_o = instret_cnt;
    assign stall_o   = stall_cnt;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: checks ctrl_sequencer (ACK_TIMEOUT=4) one cycle at a time.
// Each instruction is expanded from the architectural rules into the list of
// per-cycle expected states and outputs. The list is then replayed against
// the DUT.
module tb_ctrl_sequencer;

    localparam int TO = 4;

    localparam int ST_FETCH = 0;
    localparam int ST_DEC   = 1;
    localparam int ST_EXEC  = 2;
    localparam int ST_MEM   = 3;
    localparam int ST_WB    = 4;
    localparam int ST_INT   = 5;
    localparam int ST_STBY  = 6;

    localparam logic [6:0] C_SHIFT = 7'b0000110;
    localparam logic [6:0] C_MEM   = 7'b0000010;
    localparam logic [6:0] C_BR    = 7'b0111110;
    localparam logic [6:0] C_JMP   = 7'b0011110;
    localparam logic [6:0] C_MISC  = 7'b1111110;
    localparam logic [6:0] C_ALUR  = 7'b0001110;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op_i = '0;
    logic [2:0] func_i = '0;
    logic       int_req_i = 1'b0;
    logic       inst_ack_i = 1'b0;
    logic       data_ack_i = 1'b0;
    logic       port_ack_i = 1'b0;
    logic       inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o;
    logic       port_cyc_o, port_stb_o, port_we_o, reg_wr_o, int_o, ie_o, bus_err_o;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    ctrl_sequencer #(.OP_W(7), .FUNC_W(3), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .op_i(op_i), .func_i(func_i),
        .int_req_i(int_req_i), .inst_ack_i(inst_ack_i),
        .data_ack_i(data_ack_i), .port_ack_i(port_ack_i),
        .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o),
        .data_cyc_o(data_cyc_o), .data_stb_o(data_stb_o), .data_we_o(data_we_o),
        .port_cyc_o(port_cyc_o), .port_stb_o(port_stb_o), .port_we_o(port_we_o),
        .reg_wr_o(reg_wr_o), .int_o(int_o), .ie_o(ie_o), .bus_err_o(bus_err_o),
        .state_o(state_o)
    );

    logic [11:0] obs;
    assign obs = {inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o,
                  port_cyc_o, port_stb_o, port_we_o, reg_wr_o, int_o, ie_o, bus_err_o};

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        rst_n;
        logic [6:0]  op;
        logic [2:0]  func;
        logic        ia;
        logic        da;
        logic        pa;
        logic        irq;
        logic [2:0]  st;
        logic [11:0] outs;
    } step_t;

    step_t      exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cycle = 0;
    logic       mie = 1'b0;     // architectural interrupt-enable flag
    logic [6:0] cur_op = '0;
    logic [2:0] cur_func = '0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected output vector: fetch request, data/port request (+write),
    // register write, interrupt entry, ie flag, bus error.
    function automatic logic [11:0] ob(input logic f, input logic d, input logic p,
                                       input logic we, input logic rw, input logic io,
                                       input logic ie, input logic err);
        return {f, f, d, d, d & we, p, p, p & we, rw, io, ie, err};
    endfunction

    task automatic push(input logic r, input logic ia, input logic da, input logic pa,
                        input logic irq, input int st, input logic [11:0] o);
        step_t s;
        s.rst_n = r;
        s.op    = cur_op;
        s.func  = cur_func;
        s.ia    = ia;
        s.da    = da;
        s.pa    = pa;
        s.irq   = irq;
        s.st    = 3'(st);
        s.outs  = o;
        exp_q.push_back(s);
    endtask

    // One interrupt-entry cycle. Interrupts are disabled afterwards.
    task automatic push_int(input logic irq);
        push(1'b1, rb(), rb(), rb(), irq, ST_INT, ob(0, 0, 0, 0, 0, 1, mie, 0));
        mie = 1'b0;
    endtask

    task automatic finish_instr(input logic irq);
        if (irq && mie) push_int(irq);
    endtask

    // Expand one instruction. fw = cycles before inst ack. mw = cycles after
    // entering EXECUTE before the bus ack. sn = standby length for wait/stby.
    task automatic instr(input logic [6:0] op, input logic [2:0] func, input int fw,
                         input int mw, input logic irq, input int sn);
        int   k;
        logic inter, dbus, pbus, we, rd, sleep;
        cur_op   = op;
        cur_func = func;
        sleep    = (op == C_MISC) && (func == 3'd4 || func == 3'd5);
        k = 0;
        while (k != fw) begin
            if (k == TO) begin
                push(1, 0, rb(), rb(), irq, ST_FETCH, ob(1, 0, 0, 0, 0, 0, mie, 1));
                push_int(irq);
                return;
            end
            push(1, 0, rb(), rb(), irq, ST_FETCH, ob(1, 0, 0, 0, 0, 0, mie, 0));
            k++;
        end
        push(1, 1, rb(), rb(), irq, ST_FETCH, ob(1, 0, 0, 0, 0, 0, mie, 0));
        push(1, rb(), rb(), rb(), irq, ST_DEC, ob(0, 0, 0, 0, 0, 0, mie, 0));
        if (op[0]) begin
            push_int(irq);
            return;
        end
        if (sleep) begin
            for (int j = 0; j < sn - 1; j++)
                push(1, rb(), rb(), rb(), 0, ST_STBY, ob(0, 0, 0, 0, 0, 0, mie, 0));
            push(1, rb(), rb(), rb(), 1, ST_STBY, ob(0, 0, 0, 0, 0, 0, mie, 0));
            push_int(1'b1);
            return;
        end
        if (op == C_BR || op == C_JMP || op == C_MISC) begin
            inter = irq && mie;
            if (op == C_MISC) begin
                if (func == 3'd0 || func == 3'd2) mie = 1'b1;
                else if (func == 3'd3) mie = 1'b0;
            end
            if (inter) push_int(irq);
            return;
        end
        if (op == C_MEM && func[2] == 1'b0) begin
            dbus = (func[1] == 1'b0);
            pbus = (func[1] == 1'b1);
            we   = func[0];
            rd   = ~func[0];
            if (mw == 0) begin
                push(1, rb(), dbus ? 1'b1 : rb(), pbus ? 1'b1 : rb(), irq, ST_EXEC,
                     ob(0, dbus, pbus, we, 0, 0, mie, 0));
            end else begin
                push(1, rb(), dbus ? 1'b0 : rb(), pbus ? 1'b0 : rb(), irq, ST_EXEC,
                     ob(0, dbus, pbus, we, 0, 0, mie, 0));
                k = 0;
                while (k != mw - 1) begin
                    if (k == TO) begin
                        push(1, rb(), dbus ? 1'b0 : rb(), pbus ? 1'b0 : rb(), irq, ST_MEM,
                             ob(0, dbus, pbus, we, 0, 0, mie, 1));
                        push_int(irq);
                        return;
                    end
                    push(1, rb(), dbus ? 1'b0 : rb(), pbus ? 1'b0 : rb(), irq, ST_MEM,
                         ob(0, dbus, pbus, we, 0, 0, mie, 0));
                    k++;
                end
                push(1, rb(), dbus ? 1'b1 : rb(), pbus ? 1'b1 : rb(), irq, ST_MEM,
                     ob(0, dbus, pbus, we, 0, 0, mie, 0));
            end
            if (rd) push(1, rb(), rb(), rb(), irq, ST_WB, ob(0, 0, 0, 0, 1, 0, mie, 0));
            finish_instr(irq);
            return;
        end
        push(1, rb(), rb(), rb(), irq, ST_EXEC, ob(0, 0, 0, 0, 0, 0, mie, 0));
        push(1, rb(), rb(), rb(), irq, ST_WB, ob(0, 0, 0, 0, 1, 0, mie, 0));
        finish_instr(irq);
    endtask

    // ldm stalled in MEM, with reset asserted during the second MEM cycle.
    task automatic reset_in_mem();
        cur_op   = C_MEM;
        cur_func = 3'd0;
        push(1, 1, 0, 0, 0, ST_FETCH, ob(1, 0, 0, 0, 0, 0, mie, 0));
        push(1, 0, 0, 0, 0, ST_DEC, ob(0, 0, 0, 0, 0, 0, mie, 0));
        push(1, 0, 0, 0, 0, ST_EXEC, ob(0, 1, 0, 0, 0, 0, mie, 0));
        push(1, 0, 0, 0, 0, ST_MEM, ob(0, 1, 0, 0, 0, 0, mie, 0));
        push(0, 0, 0, 0, 0, ST_MEM, ob(0, 1, 0, 0, 0, 0, mie, 0));
        mie = 1'b0;
    endtask

    // ---------------- driver / scoreboard ----------------
    task automatic run_queue();
        step_t s;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            @(negedge clk);
            rst_n      = s.rst_n;
            op_i       = s.op;
            func_i     = s.func;
            inst_ack_i = s.ia;
            data_ack_i = s.da;
            port_ack_i = s.pa;
            int_req_i  = s.irq;
            #1;
            cycle++;
            vectors++;
            assert (state_o === s.st) else begin
                miscompares++;
                $error("FAIL state cyc %0d op %b func %0d: observed %0d expected %0d",
                       cycle, s.op, s.func, state_o, s.st);
            end
            vectors++;
            assert (obs === s.outs) else begin
                miscompares++;
                $error("FAIL outs cyc %0d st %0d op %b func %0d: observed %b expected %b",
                       cycle, s.st, s.op, s.func, obs, s.outs);
            end
        end
    endtask

    task automatic exec(input logic [6:0] op, input logic [2:0] func, input int fw,
                        input int mw, input logic irq, input int sn);
        instr(op, func, fw, mw, irq, sn);
        run_queue();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [6:0] op;
        logic [2:0] func;
        int         sel;

        // reset state, checked while rst_n is still low
        push(0, 0, 0, 0, 0, ST_FETCH, ob(1, 0, 0, 0, 0, 0, 0, 0));
        push(0, 0, 0, 0, 0, ST_FETCH, ob(1, 0, 0, 0, 0, 0, 0, 0));
        mie = 1'b0;
        run_queue();

        exec(C_ALUR, 3'd0, 1, 0, 0, 0);      // alu_reg, fetch ack on 2nd cycle
        exec(C_MEM, 3'd0, 0, 3, 0, 0);       // ldm, 3 MEM cycles
        exec(C_MISC, 3'd2, 0, 0, 0, 0);      // enai
        exec(C_MEM, 3'd3, 0, 0, 1, 0);       // out with irq -> INT
        exec(C_SHIFT, 3'd1, TO + 1, 0, 0, 0); // fetch timeout
        exec(C_MISC, 3'd2, 0, 0, 0, 0);      // enai
        exec(C_MISC, 3'd5, 0, 0, 0, 10);     // stby, 10 cycles, then INT
        exec(7'b1010101, 3'd0, 0, 0, 0, 0);  // illegal trap with ie=0
        exec(C_MEM, 3'd2, 0, TO + 2, 0, 0);  // inp MEM timeout
        exec(C_JMP, 3'd0, TO, 0, 1, 0);      // ack on the limit cycle wins
        exec(C_MEM, 3'd1, 0, TO + 1, 0, 0);  // stm ack on the MEM limit cycle
        exec(C_MISC, 3'd0, 0, 0, 1, 0);      // reti with irq: old ie=0 -> FETCH
        exec(C_MISC, 3'd3, 0, 0, 1, 0);      // disi with irq: old ie=1 -> INT
        exec(C_MISC, 3'd2, 0, 0, 0, 0);      // enai before mid-op reset
        reset_in_mem();
        run_queue();
        exec(7'b0101000, 3'd7, 0, 0, 0, 0);  // alu_imm after reset, ie=0

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       op = C_SHIFT;
                1, 9:    op = C_MEM;
                2:       op = C_BR;
                3:       op = C_JMP;
                4, 5:    op = C_MISC;
                6:       op = C_ALUR;
                7:       op = 7'($urandom_range(0, 127)) & 7'h7e;
                default: op = 7'($urandom_range(0, 127)) | 7'h01;
            endcase
            func = 3'($urandom_range(0, 7));
            if (op == C_MEM) func[2] = 1'b0;
            if (op == C_MISC && (func == 3'd4 || func == 3'd5) && !mie) func = 3'd2;
            exec(op, func, $urandom_range(0, 5), $urandom_range(0, 6),
                 1'($urandom_range(0, 1)), $urandom_range(1, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound on total run time so a stuck run still terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
